// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin share of one W-bit adder; req/a_in/b_in in, one-hot gnt, res_* result stage with ready/valid, op_count handoffs
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       op_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [IDW-1:0] ptr, sel, idx;
  logic found, can_issue, do_grant;
  logic [W:0] sum;
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  assign can_issue = state == EMPTY || res_ready;
  assign do_grant = can_issue && found && !rst;
  assign gnt = do_grant ? NREQ'(1) << sel : '0;
  assign sum = {1'b0, a_in[sel*W +: W]} + {1'b0, b_in[sel*W +: W]};
  assign res_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      res_sum <= '0;
      res_carry <= 1'b0;
      res_id <= '0;
      ptr <= '0;
      op_count <= '0;
    end else begin
      if (do_grant) begin
        state <= FULL;
        {res_carry, res_sum} <= sum;
        res_id <= sel;
        ptr <= int'(sel) == NREQ - 1 ? '0 : sel + 1'b1;
      end else if (res_valid && res_ready) begin
        state <= EMPTY;
      end
      if (res_valid && res_ready && op_count != '1) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  logic clk = 1'b0, rst, res_ready;
  logic [3:0] req, gnt;
  logic [31:0] a_in, b_in;
  logic res_valid, res_carry;
  logic [7:0] res_sum;
  logic [1:0] res_id;
  logic [15:0] op_count;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(4), .W(8), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id), .op_count(op_count)
  );

  typedef struct {
    logic [3:0] req;
    logic rdy;
    logic [31:0] a, b;
    logic [3:0] egnt;
    logic ev, ec;
    logic [7:0] es;
    logic [1:0] eid;
    logic [15:0] ecnt;
  } vec_t;
  vec_t tbl[7];

  int mptr, mid, mcnt;
  bit mfull, mc;
  logic [7:0] msum;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] outw();
    return {21'd0, res_valid, res_carry, res_sum, res_id};
  endfunction

  function automatic logic [31:0] mkw(input logic v, input logic c, input logic [7:0] s, input logic [1:0] id);
    return {21'd0, v, c, s, id};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    res_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic gnt_chk(input string n, input logic [3:0] e);
    @(negedge clk);
    chk(n, {28'd0, gnt}, {28'd0, e});
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    logic [31:0] held;
    int g, s;
    logic [3:0] eg;
    tbl[0] = '{4'b0001, 1'b1, 32'h0000007F, 32'h00000001, 4'b0001, 1'b1, 1'b0, 8'h80, 2'd0, 16'd0};
    tbl[1] = '{4'b0000, 1'b1, 32'h0000007F, 32'h00000001, 4'b0000, 1'b0, 1'b0, 8'h80, 2'd0, 16'd1};
    tbl[2] = '{4'b0100, 1'b1, 32'h00FF0000, 32'h00010000, 4'b0100, 1'b1, 1'b1, 8'h00, 2'd2, 16'd1};
    tbl[3] = '{4'b0101, 1'b1, 32'h001000FF, 32'h002000FF, 4'b0001, 1'b1, 1'b1, 8'hFE, 2'd0, 16'd2};
    tbl[4] = '{4'b0100, 1'b1, 32'h001000FF, 32'h002000FF, 4'b0100, 1'b1, 1'b0, 8'h30, 2'd2, 16'd3};
    tbl[5] = '{4'b0000, 1'b0, 32'h001000FF, 32'h002000FF, 4'b0000, 1'b1, 1'b0, 8'h30, 2'd2, 16'd3};
    tbl[6] = '{4'b0000, 1'b1, 32'h001000FF, 32'h002000FF, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd2, 16'd4};

    do_reset();
    chk("reset_out", outw(), mkw(0, 0, 8'h00, 0));
    chk("reset_cnt", {16'd0, op_count}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      res_ready = tbl[i].rdy;
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      gnt_chk($sformatf("tbl%0d_gnt", i), tbl[i].egnt);
      chk($sformatf("tbl%0d_out", i), outw(), mkw(tbl[i].ev, tbl[i].ec, tbl[i].es, tbl[i].eid));
      chk($sformatf("tbl%0d_cnt", i), {16'd0, op_count}, {16'd0, tbl[i].ecnt});
    end

    do_reset();
    req = 4'b1111;
    a_in = 32'h31211101;
    b_in = 32'h03020100;
    for (int i = 0; i < 5; i++) begin
      gnt_chk($sformatf("fair%0d_gnt", i), 4'b0001 << (i % 4));
      chk($sformatf("fair%0d_id", i), {30'd0, res_id}, (i % 4));
      chk($sformatf("fair%0d_sum", i), {24'd0, res_sum}, 8'h01 + 8'h11 * (i % 4));
    end
    chk("fair_cnt", {16'd0, op_count}, 32'd4);

    do_reset();
    req = 4'b0010;
    a_in = 32'h00000800;
    b_in = 32'h00000800;
    gnt_chk("bp_setup_gnt", 4'b0010);
    a_in = 32'h00002100;
    b_in = 32'h00000100;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gnt_chk($sformatf("bp%0d_gnt", i), 4'b0000);
      chk($sformatf("bp%0d_out", i), outw(), mkw(1, 0, 8'h10, 1));
      chk($sformatf("bp%0d_cnt", i), {16'd0, op_count}, 32'd0);
    end
    res_ready = 1'b1;
    gnt_chk("bp_rel_gnt", 4'b0010);
    chk("bp_rel_out", outw(), mkw(1, 0, 8'h22, 1));
    chk("bp_rel_cnt", {16'd0, op_count}, 32'd1);

    do_reset();
    req = 4'b1111;
    a_in = 32'h44332211;
    b_in = 32'h01010101;
    gnt_chk("mrst_setup_gnt", 4'b0001);
    chk("mrst_setup_out", outw(), mkw(1, 0, 8'h12, 0));
    rst = 1'b1;
    gnt_chk("mrst_gnt", 4'b0000);
    chk("mrst_out", outw(), mkw(0, 0, 8'h00, 0));
    chk("mrst_cnt", {16'd0, op_count}, 32'd0);
    rst = 1'b0;
    gnt_chk("mrst_after_gnt", 4'b0001);

    do_reset();
    mptr = 0; mid = 0; mcnt = 0; mfull = 0; mc = 0; msum = '0;
    for (int i = 0; i < 3000; i++) begin
      held = (i % 3 == 0) ? $urandom : a_in;
      a_in = held;
      b_in = (i % 3 == 0) ? $urandom : b_in;
      if (i % 50 == 7) begin
        a_in = 32'hFFFFFFFF;
        b_in = 32'hFFFFFFFF;
      end
      req = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      g = (rst || (mfull && !res_ready)) ? -1 : pick(req, mptr);
      eg = (g < 0) ? 4'b0000 : 4'b0001 << g;
      gnt_chk("rnd_gnt", eg);
      if (rst) begin
        mptr = 0; mid = 0; mcnt = 0; mfull = 0; mc = 0; msum = '0;
      end else begin
        if (mfull && res_ready && mcnt != 16'hFFFF) mcnt++;
        if (g >= 0) begin
          s = a_in[g*8 +: 8] + b_in[g*8 +: 8];
          msum = s[7:0];
          mc = s[8];
          mid = g;
          mfull = 1;
          mptr = (g + 1) % 4;
        end else if (mfull && res_ready) begin
          mfull = 0;
        end
      end
      chk("rnd_out", outw(), mkw(mfull, mc, msum, 2'(mid)));
      chk("rnd_cnt", {16'd0, op_count}, mcnt);
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 8-bit adder (sum plus carry-out) among several requesters. Each requester presents an operand pair and holds it until granted. The block issues one addition per cycle into a single-entry registered result stage, tagged with the requester index and subject to downstream backpressure. It sits between the chip's operand sources (pin/register front-ends) and the output drivers.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `W`, 8, operand and sum width
- `IDW`, 2, width of requester index; equals ceil(log2(NREQ))
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  NREQ  per-requester request; must stay high with stable operands until granted
- `a_in`  in  NREQ*W  operand A, requester i in bits [i*W +: W]
- `b_in`  in  NREQ*W  operand B, same packing
- `gnt`  out  NREQ  one-hot combinational grant; at most one bit high; operands sampled on that edge
- `res_valid`  out  1  result register holds an unconsumed result
- `res_ready`  in  1  downstream accepts result this cycle
- `res_sum`  out  W  low W bits of A+B
- `res_carry`  out  1  bit W of A+B
- `res_id`  out  IDW  index of requester that produced the result
- `op_count`  out  16  number of completed handoffs (res_valid & res_ready), saturating at 0xFFFF

## Operation
- The result stage is a two-state FSM.
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- Issue condition: `can_issue = (EMPTY) | (FULL & res_ready)`.
- Arbitration:
  - When `can_issue` holds and any `req` bit is high, grant the first requesting index at or after `ptr`, searching upward with wrap from NREQ-1 to 0.
  - `gnt` = one-hot of the granted index, combinational in the same cycle.
  - `gnt` = 0 when `can_issue` is low, when no `req` is high, or when `rst` is high.
- On a grant edge:
  - res_sum, res_carry = the (W+1)-bit sum of the granted requester's a and b. Zero-extend both operands; unsigned.
  - res_id = granted index.
  - FSM goes to FULL.
  - ptr = (granted index + 1) mod NREQ.
- FULL & res_ready with no grant: go to EMPTY. res_sum, res_carry and res_id keep their last values.
- FULL & !res_ready: all result outputs hold stable and no grant is issued.
- ptr changes only on a grant.
- op_count increments on every edge with res_valid & res_ready, and saturates (holds at 0xFFFF).
- A requester that drops `req` before being granted is simply skipped; no state is recorded.

## Timing
- Reset values (the edge with rst=1): res_valid=0, res_sum=0, res_carry=0, res_id=0, ptr=0, op_count=0, FSM=EMPTY. gnt=0 throughout any cycle where rst=1.
- Latency: a grant in cycle N puts the result valid in cycle N+1.
- Throughput: one result per cycle while res_ready=1 and requests are pending, including back-to-back consume and reissue in the same cycle.
- Simultaneous consume and grant: the FSM stays FULL, the new result replaces the old one, and op_count increments.
- Reset during FULL: the pending result is discarded, and the request that was granted on the reset edge is lost. Requesters re-request after reset.
- Pointer wrap: after granting NREQ-1, ptr=0.
- Overflow: 0xFF+0xFF gives res_sum=0xFE and res_carry=1. No saturation in the adder path.

## Test plan
- Single request: req=0001, a0=0x7F, b0=0x01, res_ready=1. Expect gnt=0001 in cycle 0. In cycle 1: res_valid=1, res_sum=0x80, res_carry=0, res_id=0. In cycle 2: res_valid=0 and op_count=1.
- Carry: requester 2 with a=0xFF, b=0x01. Expect res_sum=0x00, res_carry=1, res_id=2.
- Fairness: req=1111 held constantly, res_ready=1, from reset. Expect gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and res_id sequence 0, 1, 2, 3, 0 one cycle later.
- Backpressure:
  - Setup: FULL with res_sum=0x10, then res_ready=0 for 3 cycles with req=0010 pending.
  - Expect gnt=0 and all outputs stable for those 3 cycles.
  - When res_ready=1: expect gnt=0010 that cycle, the new result next cycle, and op_count +1.
- Skip and wrap: ptr=3 after granting 2, req=0101. Expect grant to index 0 (wrap), then ptr=1, then grant to index 2.
- Mid-operation reset: FULL with res_valid=1, assert rst for 1 cycle with req=1111. Expect gnt=0 during rst. After the edge, all outputs are zero and res_valid=0. The first grant after reset goes to index 0.
